// File: rtl/run_controller.sv
// Run-control sequencer for the single-cycle MIPS core.
// Qualifies every architectural state update with a one-cycle cpu_enable
// pulse. The core either auto-runs at a divided rate or single-steps on a
// debounced pushbutton. It stalls on IN until the operator confirms, and
// stops for good on HALT.
module run_controller #(
  parameter int unsigned DIV             = 25000000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 run_switch,
  input  logic                 step_button,
  input  logic                 halt_inst,
  input  logic                 in_inst,
  input  logic                 out_inst,
  output logic                 cpu_enable,
  output logic                 input_latch,
  output logic                 out_strobe,
  output logic                 waiting_input,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam int unsigned TW = $clog2(DIV);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_IN = 2'd1,
    HALTED  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   sync1_q, sync2_q;
  logic                   deb_q, deb_d;
  logic                   deb_prev_q;
  logic [DW-1:0]          deb_cnt_q, deb_cnt_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic                   run_q;
  logic [CNT_WIDTH-1:0]   count_q, count_d;

  logic                   press;
  logic                   run_fall;
  logic                   step;

  // Debouncer: the level follows the synchronized button only after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    if (sync2_q == deb_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      deb_d     = sync2_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + DW'(1);
    end
  end

  assign press = deb_q & ~deb_prev_q;

  // Button synchronizer, debounced level and its one-cycle-old copy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
    end else begin
      sync1_q    <= step_button;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
    end
  end

  // A rise of run_switch needs no special handling: the tick counter is
  // already 0 and cannot match TICK_LAST. Only the fall must mask a press.
  assign run_fall = run_q & ~run_switch;

  // Step source: divided tick in auto-run, debounced press in single-step.
  always_comb begin
    step = 1'b0;
    if (run_switch) begin
      step = (tick_q == TICK_LAST);
    end else begin
      step = press & ~run_fall;
    end
  end

  // Tick counter runs only while auto-running in RUN, otherwise it parks at 0.
  always_comb begin
    tick_d = '0;
    if (state_q == RUN && run_switch && tick_q != TICK_LAST) begin
      tick_d = tick_q + TW'(1);
    end
  end

  // Tick counter and run_switch history.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_q <= '0;
      run_q  <= 1'b0;
    end else begin
      tick_q <= tick_d;
      run_q  <= run_switch;
    end
  end

  // Next-state and commit pulses: HALT beats IN, and only a plain step commits.
  always_comb begin
    state_d     = state_q;
    cpu_enable  = 1'b0;
    input_latch = 1'b0;
    unique case (state_q)
      RUN: begin
        if (step) begin
          if (halt_inst) begin
            state_d = HALTED;
          end else if (in_inst) begin
            state_d = WAIT_IN;
          end else begin
            cpu_enable = 1'b1;
          end
        end
      end
      WAIT_IN: begin
        if (press) begin
          input_latch = 1'b1;
          cpu_enable  = 1'b1;
          state_d     = RUN;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Executed-instruction counter, saturating at all-ones.
  always_comb begin
    count_d = count_q;
    if (cpu_enable && count_q != '1) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  // Instruction counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_strobe    = cpu_enable & out_inst;
  assign waiting_input = (state_q == WAIT_IN);
  assign halted        = (state_q == HALTED);
  assign instr_count   = count_q;

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller with DIV=4, DEBOUNCE_CYCLES=3.
// Two instances share all inputs: an 8-bit counter and a 2-bit saturating one.
module tb_run_controller;

  localparam int DIV = 4;
  localparam int DEB = 3;

  logic clk;
  logic reset_n;
  logic run_switch;
  logic step_button;
  logic halt_inst;
  logic in_inst;
  logic out_inst;

  logic       en8, latch8, strobe8, wait8, halt8;
  logic [7:0] cnt8;
  logic       en2, latch2, strobe2, wait2, halt2;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;
  logic running = 1'b1;

  run_controller #(.DIV(DIV), .DEBOUNCE_CYCLES(DEB), .CNT_WIDTH(8)) dut8 (
    .clock(clk), .reset_n(reset_n), .run_switch(run_switch),
    .step_button(step_button), .halt_inst(halt_inst), .in_inst(in_inst),
    .out_inst(out_inst), .cpu_enable(en8), .input_latch(latch8),
    .out_strobe(strobe8), .waiting_input(wait8), .halted(halt8),
    .instr_count(cnt8)
  );

  run_controller #(.DIV(DIV), .DEBOUNCE_CYCLES(DEB), .CNT_WIDTH(2)) dut2 (
    .clock(clk), .reset_n(reset_n), .run_switch(run_switch),
    .step_button(step_button), .halt_inst(halt_inst), .in_inst(in_inst),
    .out_inst(out_inst), .cpu_enable(en2), .input_latch(latch2),
    .out_strobe(strobe2), .waiting_input(wait2), .halted(halt2),
    .instr_count(cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #60000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int S_RUN  = 0;
  localparam int S_WAIT = 1;
  localparam int S_HALT = 2;

  int   m_state;
  logic m_s1, m_s2;       // button after one and two register stages
  logic m_lvl, m_prev_lvl;
  logic m_prev_run;
  int   m_diff;           // consecutive cycles synced button disagreed with level
  int   m_phase;          // cycles spent auto-running, modulo DIV
  int   m_cnt8, m_cnt2;

  function automatic logic m_press();
    return m_lvl && !m_prev_lvl;
  endfunction

  function automatic logic m_step();
    if (run_switch != m_prev_run) return 1'b0;
    if (run_switch) return (m_phase == DIV - 1);
    return m_press();
  endfunction

  function automatic logic m_en();
    return (m_state == S_RUN && m_step() && !halt_inst && !in_inst) ||
           (m_state == S_WAIT && m_press());
  endfunction

  function automatic logic m_latch();
    return (m_state == S_WAIT) && m_press();
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state = S_RUN; m_s1 = 0; m_s2 = 0; m_lvl = 0; m_prev_lvl = 0;
      m_prev_run = 0; m_diff = 0; m_phase = 0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      logic e, st, pr;
      e  = m_en();
      st = m_step();
      pr = m_press();
      if (e) begin
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
      m_phase = (m_state == S_RUN && run_switch) ? (m_phase + 1) % DIV : 0;
      if (m_state == S_RUN && st) begin
        if (halt_inst) m_state = S_HALT;
        else if (in_inst) m_state = S_WAIT;
      end else if (m_state == S_WAIT && pr) begin
        m_state = S_RUN;
      end
      m_prev_lvl = m_lvl;
      if (m_s2 != m_lvl) begin
        m_diff++;
        if (m_diff == DEB) begin
          m_lvl  = m_s2;
          m_diff = 0;
        end
      end else begin
        m_diff = 0;
      end
      m_s2 = m_s1;
      m_s1 = step_button;
      m_prev_run = run_switch;
    end
  end

  // ---------------- per-cycle comparison ----------------
  logic prev_en8 = 1'b0;
  always @(negedge clk) begin
    if (running) begin
      chk("cpu_enable8",    en8,     m_en());
      chk("cpu_enable2",    en2,     m_en());
      chk("input_latch8",   latch8,  m_latch());
      chk("input_latch2",   latch2,  m_latch());
      chk("out_strobe8",    strobe8, m_en() && out_inst);
      chk("out_strobe2",    strobe2, m_en() && out_inst);
      chk("waiting_input8", wait8,   m_state == S_WAIT);
      chk("waiting_input2", wait2,   m_state == S_WAIT);
      chk("halted8",        halt8,   m_state == S_HALT);
      chk("halted2",        halt2,   m_state == S_HALT);
      chk("instr_count8",   cnt8,    m_cnt8);
      chk("instr_count2",   cnt2,    m_cnt2);
      chk("no_back_to_back", en8 & prev_en8, 0);
      prev_en8 <= en8;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic next();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [19:0] pat;
    int n, nl, ne;

    reset_n = 0; run_switch = 1; step_button = 0;
    halt_inst = 0; in_inst = 0; out_inst = 0;
    repeat (3) next();

    // 1: auto-run from reset release, enables in cycles 4, 8, 12
    reset_n = 1;
    pat = '0;
    for (int i = 0; i < 12; i++) begin
      #1 pat[i] = en8;
      next();
    end
    #1;
    chk("auto_pattern", {20'b0, pat[11:0]}, 32'h888);
    chk("auto_count8", cnt8, 3);
    chk("auto_count2", cnt2, 3);
    next(); next();
    reset_n = 0;
    #1;
    chk("async_reset_outs", {en8, latch8, strobe8, wait8, halt8, cnt8}, 0);
    next();

    // 2: single-step, button sampled high at edge k -> enable after edge k+4
    run_switch = 0;
    reset_n = 1;
    repeat (4) next();
    step_button = 1;
    pat = '0;
    for (int j = 0; j < 20; j++) begin
      next();
      #1 pat[j] = en8;
    end
    chk("step_pattern", pat, 20'h00010);
    step_button = 0;
    repeat (8) next();
    step_button = 1;
    next(); next();
    step_button = 0;
    n = 0;
    repeat (12) begin next(); #1 n += int'(en8); end
    chk("glitch_no_step", n, 0);

    // 3: IN stall in auto-run, then confirm
    run_switch = 1;
    in_inst = 1;
    n = 0;
    repeat (110) begin next(); #1 n += int'(en8); end
    chk("stall_no_enable", n, 0);
    chk("stall_waiting", wait8, 1);
    in_inst = 0;
    step_button = 1;
    nl = 0;
    for (int j = 0; j < 10; j++) begin
      next();
      #1;
      if (latch8) begin
        nl++;
        chk("confirm_with_enable", en8, 1);
        next();
        #1 chk("confirm_leaves_wait", wait8, 0);
      end
    end
    chk("confirm_once", nl, 1);
    step_button = 0;
    repeat (8) next();

    // 4: button already held when WAIT_IN entered (step mode)
    run_switch = 0;
    in_inst = 1;
    repeat (3) next();
    step_button = 1;
    repeat (12) next();
    #1 chk("held_enter_wait", wait8, 1);
    step_button = 0;
    next(); next();
    step_button = 1;
    nl = 0;
    repeat (12) begin next(); #1 nl += int'(latch8); end
    chk("held_short_release", nl, 0);
    chk("held_still_wait", wait8, 1);
    step_button = 0;
    repeat (6) next();
    #1 chk("release_no_confirm", wait8, 1);
    step_button = 1;
    nl = 0;
    repeat (10) begin next(); #1 nl += int'(latch8); end
    chk("new_press_confirms", nl, 1);
    chk("new_press_left_wait", wait8, 0);
    in_inst = 0;
    step_button = 0;
    repeat (8) next();

    // 5: HALT together with IN
    run_switch = 1;
    halt_inst = 1;
    in_inst = 1;
    n = 0; nl = 0;
    repeat (10) begin next(); #1 begin n += int'(en8); nl += int'(latch8); end end
    chk("halt_halted", halt8, 1);
    chk("halt_no_enable", n, 0);
    chk("halt_no_latch", nl, 0);
    step_button = 1;
    repeat (8) begin next(); #1 begin n += int'(en8); nl += int'(latch8); end end
    step_button = 0;
    repeat (8) begin next(); #1 n += int'(en8); end
    run_switch = 0;
    repeat (4) begin next(); #1 n += int'(en8); end
    run_switch = 1;
    repeat (4) begin next(); #1 n += int'(en8); end
    chk("halt_ignores_inputs", n + nl, 0);
    chk("halt_stays", halt8, 1);
    reset_n = 0;
    halt_inst = 0;
    in_inst = 0;
    #1 chk("halt_reset_clears", {halt8, wait8, cnt8}, 0);
    next();

    // 6: OUT strobes and counter saturation
    out_inst = 1;
    reset_n = 1;
    ne = 0;
    for (int i = 0; i < 24; i++) begin
      #1;
      if (en8) ne++;
      chk("strobe_tracks_enable", strobe8, en8);
      next();
    end
    #1;
    chk("out_commits", ne, 6);
    chk("out_count8", cnt8, 6);
    chk("out_count2_saturated", cnt2, 3);

    running = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
